// File: rtl/demux_pkg.sv
// Shared types and defaults for the 1-to-2 stream demultiplexer.
// Optional delivered-word counters are enabled with DEMUX_CNT_EN.
package demux_pkg;

    typedef enum logic {
        CH_B = 1'b0,
        CH_A = 1'b1
    } chan_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    localparam int DEMUX_W     = 4;
    localparam int DEMUX_CNT_W = 8;

endpackage

// File: rtl/demux_out_reg.sv
// One-entry output register for one demux channel.
// Optional delivered-word counter is enabled with DEMUX_CNT_EN.
module demux_out_reg
    import demux_pkg::*;
#(
    parameter int W     = DEMUX_W,
    parameter int CNT_W = DEMUX_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     din,
    output logic             room,
    output logic             valid,
    input  logic             ready,
`ifdef DEMUX_CNT_EN
    output logic [CNT_W-1:0] cnt,
`endif
    output logic [W-1:0]     data
);

    buf_state_e state;

    assign valid = (state == FULL);
    // Space exists if empty or the held word leaves this cycle
    assign room  = (state == EMPTY) | ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            data  <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (load) begin
                        state <= FULL;
                        data  <= din;
                    end
                end
                FULL: begin
                    if (load) begin
                        data <= din;
                    end else if (ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef DEMUX_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (valid && ready) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/demux_stream_router.sv
// Registered 1-to-2 valid/ready demultiplexer steered by s_sel.
// Optional per-channel counters (a_cnt/b_cnt) with DEMUX_CNT_EN.
module demux_stream_router
    import demux_pkg::*;
#(
    parameter int W     = DEMUX_W,
    parameter int CNT_W = DEMUX_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    input  logic             s_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [W-1:0]     a_data,
    output logic             b_valid,
    input  logic             b_ready,
`ifdef DEMUX_CNT_EN
    output logic [CNT_W-1:0] a_cnt,
    output logic [CNT_W-1:0] b_cnt,
`endif
    output logic [W-1:0]     b_data
);

    logic a_room;
    logic b_room;
    logic a_load;
    logic b_load;

    always_comb begin
        s_ready = 1'b0;
        a_load  = 1'b0;
        b_load  = 1'b0;
        unique case (1'b1)
            (s_sel == CH_A): begin
                s_ready = a_room;
                a_load  = s_valid & a_room;
            end
            default: begin
                s_ready = b_room;
                b_load  = s_valid & b_room;
            end
        endcase
    end

    demux_out_reg #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (a_load),
        .din   (s_data),
        .room  (a_room),
        .valid (a_valid),
        .ready (a_ready),
`ifdef DEMUX_CNT_EN
        .cnt   (a_cnt),
`endif
        .data  (a_data)
    );

    demux_out_reg #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (b_load),
        .din   (s_data),
        .room  (b_room),
        .valid (b_valid),
        .ready (b_ready),
`ifdef DEMUX_CNT_EN
        .cnt   (b_cnt),
`endif
        .data  (b_data)
    );

endmodule
